// File: rtl/bnn_seq_if.sv
// Handshake bundle between the BNN inference sequencer and its surroundings:
// host control, serial load strobes, and the three layer start/done pairs.
interface bnn_seq_if;
  logic       start;
  logic       mode;
  logic       bit_valid;
  logic       pix_shift_en;
  logic       w_shift_en;
  logic       l1_start;
  logic       l2_start;
  logic       l3_start;
  logic       l1_done;
  logic       l2_done;
  logic       l3_done;
  logic [3:0] l3_answer;
  logic [2:0] state;
  logic [3:0] answer;
  logic       result_valid;
  logic [1:0] err_code;
  logic       busy;

  // Host / datapath side: drives control, serial strobes and layer completions.
  modport master (
    output start, mode, bit_valid, l1_done, l2_done, l3_done, l3_answer,
    input  pix_shift_en, w_shift_en, l1_start, l2_start, l3_start,
    input  state, answer, result_valid, err_code, busy
  );

  // Sequencer side.
  modport slave (
    input  start, mode, bit_valid, l1_done, l2_done, l3_done, l3_answer,
    output pix_shift_en, w_shift_en, l1_start, l2_start, l3_start,
    output state, answer, result_valid, err_code, busy
  );
endinterface

// File: rtl/bnn_sequencer.sv
// Inference controller for the MNIST BNN: serial pixel/weight load, then the
// L1 -> L2 -> L3 chain with start pulses, per-layer watchdog and latched answer.
module bnn_sequencer #(
  parameter int N_PIXELS = 784,
  parameter int N_WBITS  = 2320,
  parameter int TIMEOUT  = 4096,
  parameter int CNT_W    = 12
) (
  input logic      clk,
  input logic      reset,
  bnn_seq_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_L1    = 3'd2;
  localparam logic [2:0] S_L2    = 3'd3;
  localparam logic [2:0] S_L3    = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;

  localparam logic [CNT_W-1:0] PIX_LAST  = CNT_W'(N_PIXELS);
  localparam logic [CNT_W-1:0] W_LAST    = CNT_W'(N_WBITS);
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);

  logic [2:0]       state_reg, state_next;
  logic [CNT_W-1:0] pix_cnt_reg, pix_cnt_next;
  logic [CNT_W-1:0] w_cnt_reg, w_cnt_next;
  logic [CNT_W-1:0] wdog_reg, wdog_next;
  logic             eff_mode_reg, eff_mode_next;
  logic             weights_loaded_reg, weights_loaded_next;
  logic [3:0]       answer_reg, answer_next;
  logic [1:0]       err_code_reg, err_code_next;

  logic       pix_en;
  logic       w_en;
  logic       in_load;
  logic       pulse_cycle;
  logic       cur_done;
  logic [2:0] layer_sel;
  logic [2:0] layer_start;
  logic [2:0] layer_done;

  assign in_load     = (state_reg == S_LOAD);
  assign pulse_cycle = (wdog_reg == '0);
  assign layer_done  = {bus.l3_done, bus.l2_done, bus.l1_done};

  // wdog is zero only in the first cycle of a layer state, which doubles as the pulse cycle.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_layer
      assign layer_sel[gi]   = (state_reg == S_L1 + 3'(gi));
      assign layer_start[gi] = layer_sel[gi] && pulse_cycle;
    end
  endgenerate

  assign cur_done = |(layer_sel & layer_done) && !pulse_cycle;

  assign pix_en = in_load && bus.bit_valid && (pix_cnt_reg < PIX_LAST);
  assign w_en   = in_load && bus.bit_valid && !eff_mode_reg && (w_cnt_reg < W_LAST);

  always_comb begin
    state_next          = state_reg;
    pix_cnt_next        = pix_en ? pix_cnt_reg + 1'b1 : pix_cnt_reg;
    w_cnt_next          = w_en ? w_cnt_reg + 1'b1 : w_cnt_reg;
    wdog_next           = wdog_reg;
    eff_mode_next       = eff_mode_reg;
    weights_loaded_next = weights_loaded_reg;
    answer_next         = answer_reg;
    err_code_next       = err_code_reg;

    case (state_reg)
      S_IDLE, S_DONE, S_ERROR: begin
        if (bus.start) begin
          state_next    = S_LOAD;
          eff_mode_next = bus.mode && weights_loaded_reg;
          pix_cnt_next  = '0;
          w_cnt_next    = '0;
          wdog_next     = '0;
          err_code_next = 2'd0;
        end
      end
      S_LOAD: begin
        // Completion uses the post-shift counts so L1 follows the last bit directly.
        if (pix_cnt_next == PIX_LAST && (eff_mode_reg || w_cnt_next == W_LAST)) begin
          state_next = S_L1;
          wdog_next  = '0;
          if (!eff_mode_reg) weights_loaded_next = 1'b1;
        end
      end
      S_L1, S_L2, S_L3: begin
        wdog_next = wdog_reg + 1'b1;
        if (cur_done) begin
          wdog_next = '0;
          if (state_reg == S_L3) begin
            answer_next = bus.l3_answer;
            if (bus.l3_answer > 4'd9) begin
              state_next    = S_ERROR;
              err_code_next = 2'd2;
            end else begin
              state_next = S_DONE;
            end
          end else begin
            state_next = state_reg + 3'd1;
          end
        end else if (wdog_reg == WDOG_LAST) begin
          state_next    = S_ERROR;
          err_code_next = 2'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg          <= S_IDLE;
      pix_cnt_reg        <= '0;
      w_cnt_reg          <= '0;
      wdog_reg           <= '0;
      eff_mode_reg       <= 1'b0;
      weights_loaded_reg <= 1'b0;
      answer_reg         <= 4'd0;
      err_code_reg       <= 2'd0;
    end else begin
      state_reg          <= state_next;
      pix_cnt_reg        <= pix_cnt_next;
      w_cnt_reg          <= w_cnt_next;
      wdog_reg           <= wdog_next;
      eff_mode_reg       <= eff_mode_next;
      weights_loaded_reg <= weights_loaded_next;
      answer_reg         <= answer_next;
      err_code_reg       <= err_code_next;
    end
  end

  assign bus.pix_shift_en = pix_en;
  assign bus.w_shift_en   = w_en;
  assign bus.l1_start     = layer_start[0];
  assign bus.l2_start     = layer_start[1];
  assign bus.l3_start     = layer_start[2];
  assign bus.state        = state_reg;
  assign bus.answer       = answer_reg;
  assign bus.result_valid = (state_reg == S_DONE);
  assign bus.err_code     = err_code_reg;
  assign bus.busy         = in_load || (|layer_sel);

endmodule

// File: tb/tb_bnn_sequencer.sv
// Self-checking bench for bnn_sequencer: scripted layer responder plus a
// scoreboard of expected final status popped when a run ends.
module tb_bnn_sequencer;
  localparam int N_PIX = 784;
  localparam int N_W   = 2320;
  localparam int TMO   = 4096;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_L1    = 3'd2;
  localparam logic [2:0] S_L2    = 3'd3;
  localparam logic [2:0] S_L3    = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  bnn_seq_if bus();

  bnn_sequencer #(
    .N_PIXELS(N_PIX),
    .N_WBITS (N_W),
    .TIMEOUT (TMO),
    .CNT_W   (12)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    logic [3:0] ans;
    logic [1:0] err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  int   lat[3];
  int   cnt[3];
  logic stale2 = 1'b0;

  // Layer responder: done pulse lat[i] cycles after the start pulse; lat 0 = never.
  initial begin
    lat = '{5, 10, 20};
    cnt = '{0, 0, 0};
    bus.l1_done = 1'b0;
    bus.l2_done = 1'b0;
    bus.l3_done = 1'b0;
    forever begin
      logic [2:0] pulse;
      @(posedge clk);
      #1;
      pulse = 3'b000;
      for (int i = 0; i < 3; i++) begin
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) pulse[i] = 1'b1;
        end
      end
      if (bus.l1_start) cnt[0] = lat[0];
      if (bus.l2_start) cnt[1] = lat[1];
      if (bus.l3_start) cnt[2] = lat[2];
      if (reset) cnt = '{0, 0, 0};
      bus.l1_done = pulse[0];
      bus.l2_done = pulse[1] | stale2;
      bus.l3_done = pulse[2];
    end
  end

  // Scoreboard monitor: pop one expectation whenever a run finishes from a layer state.
  initial begin
    logic [2:0] prev_st;
    exp_t e;
    prev_st = S_IDLE;
    forever begin
      @(negedge clk);
      if (!reset && (bus.state === S_DONE || bus.state === S_ERROR) &&
          (prev_st === S_L1 || prev_st === S_L2 || prev_st === S_L3)) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected_end: state=%0d with no expected result queued", bus.state);
        end else begin
          e = sb.pop_front();
          if ({bus.state, bus.answer, bus.err_code} !== {e.st, e.ans, e.err}) begin
            bad++;
            $display("FAIL sb_result: got state=%0d answer=%0d err=%0d, want state=%0d answer=%0d err=%0d",
                     bus.state, bus.answer, bus.err_code, e.st, e.ans, e.err);
          end
          total++;
          if (bus.result_valid !== (e.st == S_DONE) || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL sb_status: got result_valid=%b busy=%b, want result_valid=%b busy=0",
                     bus.result_valid, bus.busy, (e.st == S_DONE));
          end
        end
      end
      prev_st = bus.state;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  function automatic exp_t mk(input logic [2:0] st, input logic [3:0] ans, input logic [1:0] err);
    exp_t e;
    e.st = st; e.ans = ans; e.err = err;
    return e;
  endfunction

  task automatic do_load(input logic m, output int pn, output int wn, output int lc);
    @(negedge clk);
    bus.start = 1'b1; bus.mode = m; bus.bit_valid = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    pn = 0; wn = 0; lc = 0;
    while (bus.state === S_LOAD && lc < 6000) begin
      if (bus.pix_shift_en) pn++;
      if (bus.w_shift_en) wn++;
      lc++;
      @(negedge clk);
    end
    bus.bit_valid = 1'b0;
  endtask

  task automatic count_state(input logic [2:0] s, input int bound, output int n);
    n = 0;
    while (bus.state === s && n < bound) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_end();
    int n = 0;
    while (bus.state !== S_DONE && bus.state !== S_ERROR && n < 20000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [17:0] obs;
    bus.start = 1'b0; bus.mode = 1'b0; bus.bit_valid = 1'b0; bus.l3_answer = 4'd0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    obs = {bus.state, bus.answer, bus.err_code, bus.result_valid, bus.busy,
           bus.pix_shift_en, bus.w_shift_en, bus.l1_start, bus.l2_start, bus.l3_start};
    total++;
    if (obs !== 18'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0", obs);
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (bus.state !== S_IDLE) begin
      bad++;
      $display("FAIL reset_idle_hold: got state=%0d want %0d", bus.state, S_IDLE);
    end
    $display("test_reset done");
  endtask

  task automatic test_mode1_after_reset();
    int pn, wn, lc;
    lat = '{5, 10, 20};
    bus.l3_answer = 4'd7;
    sb.push_back(mk(S_DONE, 4'd7, 2'd0));
    do_load(1'b1, pn, wn, lc);
    total++;
    if (pn !== N_PIX || wn !== N_W || lc !== N_W) begin
      bad++;
      $display("FAIL first_load_counts: got pix=%0d w=%0d cycles=%0d want %0d %0d %0d", pn, wn, lc, N_PIX, N_W, N_W);
    end
    total++;
    if (bus.state !== S_L1 || bus.l1_start !== 1'b1) begin
      bad++;
      $display("FAIL l1_entry: got state=%0d l1_start=%b want %0d 1", bus.state, bus.l1_start, S_L1);
    end
    @(negedge clk);
    total++;
    if (bus.l1_start !== 1'b0 || bus.state !== S_L1) begin
      bad++;
      $display("FAIL l1_start_width: got l1_start=%b state=%0d want 0 %0d", bus.l1_start, bus.state, S_L1);
    end
    wait_end();
    $display("test_mode1_after_reset: pix=%0d w=%0d load_cycles=%0d answer=%0d", pn, wn, lc, bus.answer);
  endtask

  task automatic test_reuse();
    int pn, wn, lc;
    bus.l3_answer = 4'd4;
    sb.push_back(mk(S_DONE, 4'd4, 2'd0));
    do_load(1'b1, pn, wn, lc);
    total++;
    if (pn !== N_PIX || wn !== 0 || lc !== N_PIX) begin
      bad++;
      $display("FAIL reuse_load_counts: got pix=%0d w=%0d cycles=%0d want %0d 0 %0d", pn, wn, lc, N_PIX, N_PIX);
    end
    wait_end();
    $display("test_reuse: pix=%0d w=%0d load_cycles=%0d", pn, wn, lc);
  endtask

  task automatic test_layers();
    int pn, wn, lc, n1, n2, n3;
    lat = '{5, 10, 20};
    bus.l3_answer = 4'd7;
    sb.push_back(mk(S_DONE, 4'd7, 2'd0));
    do_load(1'b0, pn, wn, lc);
    total++;
    if (wn !== N_W || lc !== N_W) begin
      bad++;
      $display("FAIL reload_counts: got w=%0d cycles=%0d want %0d %0d", wn, lc, N_W, N_W);
    end
    count_state(S_L1, 100, n1);
    count_state(S_L2, 100, n2);
    count_state(S_L3, 100, n3);
    total++;
    if (n1 !== 6 || n2 !== 11 || n3 !== 21) begin
      bad++;
      $display("FAIL layer_latency: got L1=%0d L2=%0d L3=%0d want 6 11 21", n1, n2, n3);
    end
    total++;
    if (bus.state !== S_DONE || bus.answer !== 4'd7 || bus.result_valid !== 1'b1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL done_status: got state=%0d answer=%0d rv=%b busy=%b want 5 7 1 0",
               bus.state, bus.answer, bus.result_valid, bus.busy);
    end
    $display("test_layers: L1=%0d L2=%0d L3=%0d cycles", n1, n2, n3);
  endtask

  task automatic test_stale_done();
    int pn, wn, lc, n1, n2;
    lat = '{3, 0, 3};
    stale2 = 1'b1;
    bus.l3_answer = 4'd2;
    sb.push_back(mk(S_DONE, 4'd2, 2'd0));
    do_load(1'b1, pn, wn, lc);
    count_state(S_L1, 100, n1);
    count_state(S_L2, 100, n2);
    stale2 = 1'b0;
    total++;
    if (n1 !== 4 || n2 !== 2) begin
      bad++;
      $display("FAIL stale_done: got L1=%0d L2=%0d want 4 2", n1, n2);
    end
    wait_end();
    $display("test_stale_done: L2 cycles with stale done=%0d", n2);
  endtask

  task automatic test_timeout();
    int pn, wn, lc, n1, n2;
    lat = '{3, 0, 3};
    sb.push_back(mk(S_ERROR, 4'd2, 2'd1));
    do_load(1'b1, pn, wn, lc);
    count_state(S_L1, 100, n1);
    count_state(S_L2, TMO + 100, n2);
    total++;
    if (n2 !== TMO || bus.state !== S_ERROR || bus.err_code !== 2'd1 || bus.result_valid !== 1'b0) begin
      bad++;
      $display("FAIL watchdog: got L2=%0d state=%0d err=%0d rv=%b want %0d 6 1 0",
               n2, bus.state, bus.err_code, bus.result_valid, TMO);
    end
    $display("test_timeout: L2 cycles=%0d err=%0d", n2, bus.err_code);
  endtask

  task automatic test_timeout_edge();
    int pn, wn, lc, n1, n2;
    lat = '{3, TMO - 1, 3};
    bus.l3_answer = 4'd9;
    sb.push_back(mk(S_DONE, 4'd9, 2'd0));
    do_load(1'b1, pn, wn, lc);
    count_state(S_L1, 100, n1);
    count_state(S_L2, TMO + 100, n2);
    total++;
    if (n2 !== TMO || bus.state !== S_L3) begin
      bad++;
      $display("FAIL done_at_terminal: got L2=%0d state=%0d want %0d %0d", n2, bus.state, TMO, S_L3);
    end
    wait_end();
    $display("test_timeout_edge: L2 cycles=%0d final state=%0d", n2, bus.state);
  endtask

  task automatic test_bad_answer();
    int pn, wn, lc;
    lat = '{2, 2, 2};
    bus.l3_answer = 4'd12;
    sb.push_back(mk(S_ERROR, 4'd12, 2'd2));
    do_load(1'b1, pn, wn, lc);
    wait_end();
    total++;
    if (bus.state !== S_ERROR || bus.err_code !== 2'd2 || bus.answer !== 4'd12) begin
      bad++;
      $display("FAIL bad_answer: got state=%0d err=%0d answer=%0d want 6 2 12", bus.state, bus.err_code, bus.answer);
    end
    bus.l3_answer = 4'd5;
    sb.push_back(mk(S_DONE, 4'd5, 2'd0));
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    total++;
    if (bus.state !== S_LOAD || bus.err_code !== 2'd0 || bus.result_valid !== 1'b0 || bus.answer !== 4'd12) begin
      bad++;
      $display("FAIL restart_from_error: got state=%0d err=%0d rv=%b answer=%0d want 1 0 0 12",
               bus.state, bus.err_code, bus.result_valid, bus.answer);
    end
    bus.bit_valid = 1'b1;
    count_state(S_LOAD, 6000, lc);
    bus.bit_valid = 1'b0;
    wait_end();
    $display("test_bad_answer: restart load cycles=%0d answer=%0d", lc + 1, bus.answer);
  endtask

  task automatic test_start_busy();
    int pn, wn, lc, n1;
    lat = '{5, 4, 4};
    bus.l3_answer = 4'd1;
    sb.push_back(mk(S_DONE, 4'd1, 2'd0));
    do_load(1'b1, pn, wn, lc);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    count_state(S_L1, 100, n1);
    total++;
    if (n1 !== 4 || bus.state !== S_L2) begin
      bad++;
      $display("FAIL start_while_busy: got remaining L1=%0d state=%0d want 4 %0d", n1, bus.state, S_L2);
    end
    wait_end();
    $display("test_start_busy: remaining L1 cycles=%0d", n1);
  endtask

  task automatic test_reset_mid();
    int pn, wn, lc, n1;
    logic [17:0] obs;
    lat = '{3, 50, 3};
    bus.l3_answer = 4'd6;
    do_load(1'b1, pn, wn, lc);
    count_state(S_L1, 100, n1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    obs = {bus.state, bus.answer, bus.err_code, bus.result_valid, bus.busy,
           bus.pix_shift_en, bus.w_shift_en, bus.l1_start, bus.l2_start, bus.l3_start};
    total++;
    if (obs !== 18'd0) begin
      bad++;
      $display("FAIL async_reset_mid_l2: got %h want 0", obs);
    end
    @(negedge clk);
    reset = 1'b0;
    sb.push_back(mk(S_DONE, 4'd6, 2'd0));
    do_load(1'b1, pn, wn, lc);
    total++;
    if (wn !== N_W) begin
      bad++;
      $display("FAIL weights_flag_cleared: got w=%0d want %0d", wn, N_W);
    end
    wait_end();
    $display("test_reset_mid: post-reset w shifts=%0d", wn);
  endtask

  initial begin
    bus.start = 1'b0; bus.mode = 1'b0; bus.bit_valid = 1'b0; bus.l3_answer = 4'd0;
    test_reset();
    test_mode1_after_reset();
    test_reuse();
    test_layers();
    test_stale_done();
    test_timeout();
    test_timeout_edge();
    test_bad_answer();
    test_start_busy();
    test_reset_mid();
    repeat (2) @(negedge clk);
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending results want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
